mem_arbiter: RTL and testbench

- Shares the single-port, byte-addressed, big-endian data memory between two requesters: instruction fetch (port A, word reads only) and load/store unit (port B, byte/half/word reads and writes).
- Arbitrates round-robin, checks alignment and bounds, and drives the memory's enable/write/byte controls from registered state.
- Splits halfword stores into two byte writes, because the memory supports only byte and word writes.
- Returns registered read data with a one-cycle ack pulse.

---
 rtl/mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one big-endian byte memory between fetch (A) and LSU (B) ports.
// Checks alignment/bounds, splits halfword stores into two byte writes, registered ack/rdata.
module mem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic        b_we,
  input  logic [1:0]  b_size,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_write_op,
  output logic        mem_byte_op,
  input  logic [31:0] mem_rdata32,
  input  logic [7:0]  mem_rdata8
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic        port_b_q, port_b_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_byte_q, mem_byte_d;
  logic        a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic        b_ack_q, b_ack_d, b_err_q, b_err_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;

  logic        grant_b;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        misalign;
  logic [32:0] last_byte;
  logic        chk_err;
  logic [31:0] rd_val;
  logic        resp;
  logic        resp_err;
  logic [31:0] resp_data;

  // Port A is always a word read; last byte is computed in 33 bits so top-of-space wrap is an error.
  always_comb begin
    grant_b   = b_req && (!a_req || !last_b_q);
    sel_addr  = grant_b ? b_addr : a_addr;
    sel_size  = grant_b ? b_size : SZ_WORD;
    sel_we    = grant_b && b_we;
    sel_wdata = grant_b ? b_wdata : 32'd0;
    misalign  = 1'b0;
    last_byte = {1'b0, sel_addr};
    case (sel_size)
      SZ_HALF: begin
        misalign  = sel_addr[0];
        last_byte = {1'b0, sel_addr} + 33'd1;
      end
      SZ_WORD: begin
        misalign  = |sel_addr[1:0];
        last_byte = {1'b0, sel_addr} + 33'd3;
      end
      default: ;
    endcase
    chk_err = (sel_size == SZ_BAD) || misalign || (last_byte > {1'b0, ADDR_LIMIT});
  end

  always_comb begin
    case (size_q)
      SZ_WORD: rd_val = mem_rdata32;
      SZ_HALF: rd_val = {16'd0, mem_rdata32[31:16]};
      default: rd_val = {24'd0, mem_rdata8};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    port_b_d    = port_b_q;
    we_d        = we_q;
    size_d      = size_q;
    lo_byte_d   = lo_byte_q;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;
    mem_en_d    = 1'b0;
    mem_write_d = 1'b0;
    mem_byte_d  = 1'b0;
    a_ack_d     = 1'b0;
    a_err_d     = 1'b0;
    b_ack_d     = 1'b0;
    b_err_d     = 1'b0;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
    resp        = 1'b0;
    resp_err    = 1'b0;
    resp_data   = 32'd0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          last_b_d  = grant_b;
          port_b_d  = grant_b;
          we_d      = sel_we;
          size_d    = sel_size;
          lo_byte_d = sel_wdata[7:0];
          if (chk_err) begin
            state_d  = RESP;
            resp     = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d     = ACC1;
            mem_en_d    = 1'b1;
            mem_addr_d  = sel_addr;
            mem_write_d = sel_we;
            mem_byte_d  = sel_we && (sel_size != SZ_WORD);
            if (sel_we) begin
              case (sel_size)
                SZ_WORD: mem_wdata_d = sel_wdata;
                SZ_HALF: mem_wdata_d = {24'd0, sel_wdata[15:8]};
                default: mem_wdata_d = {24'd0, sel_wdata[7:0]};
              endcase
            end
          end
        end
      end
      ACC1: begin
        if (we_q && (size_q == SZ_HALF)) begin
          // Second half of a split halfword store: low byte to the next address.
          state_d     = ACC2;
          mem_en_d    = 1'b1;
          mem_write_d = 1'b1;
          mem_byte_d  = 1'b1;
          mem_addr_d  = mem_addr_q + 32'd1;
          mem_wdata_d = {24'd0, lo_byte_q};
        end else begin
          state_d   = RESP;
          resp      = 1'b1;
          resp_data = we_q ? 32'd0 : rd_val;
        end
      end
      ACC2: begin
        state_d = RESP;
        resp    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (resp) begin
      if (port_b_d) begin
        b_ack_d   = 1'b1;
        b_err_d   = resp_err;
        b_rdata_d = resp_data;
      end else begin
        a_ack_d   = 1'b1;
        a_err_d   = resp_err;
        a_rdata_d = resp_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      port_b_q    <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      lo_byte_q   <= 8'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_byte_q  <= 1'b0;
      a_ack_q     <= 1'b0;
      a_err_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      b_err_q     <= 1'b0;
      a_rdata_q   <= 32'd0;
      b_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      port_b_q    <= port_b_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lo_byte_q   <= lo_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_write_q <= mem_write_d;
      mem_byte_q  <= mem_byte_d;
      a_ack_q     <= a_ack_d;
      a_err_q     <= a_err_d;
      b_ack_q     <= b_ack_d;
      b_err_q     <= b_err_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_ack        = a_ack_q;
  assign a_err        = a_err_q;
  assign a_rdata      = a_rdata_q;
  assign b_ack        = b_ack_q;
  assign b_err        = b_err_q;
  assign b_rdata      = b_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_en       = mem_en_q;
  assign mem_write_op = mem_write_q;
  assign mem_byte_op  = mem_byte_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus scoreboard of expected responses, with a
// behavioural big-endian memory (64 real bytes, higher addresses return an address pattern).
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0;
  logic [31:0] a_addr = 32'd0;
  logic        a_ack, a_err;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0;
  logic [31:0] b_addr = 32'd0;
  logic        b_we = 1'b0;
  logic [1:0]  b_size = 2'b00;
  logic [31:0] b_wdata = 32'd0;
  logic        b_ack, b_err;
  logic [31:0] b_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_en, mem_write_op, mem_byte_op;
  logic [31:0] mem_rdata32;
  logic [7:0]  mem_rdata8;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        port_b;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        port_b;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  exp_t        sb[$];
  exp_t        got;
  logic [31:0] en_log[$];
  logic [7:0]  mem [0:63];
  logic        mem_clr = 1'b1;

  mem_arbiter #(.ADDR_LIMIT(32'd1000000)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_we(b_we), .b_size(b_size), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en),
    .mem_write_op(mem_write_op), .mem_byte_op(mem_byte_op),
    .mem_rdata32(mem_rdata32), .mem_rdata8(mem_rdata8)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rdb(input logic [31:0] a);
    if (a < 32'd64) return mem[a[5:0]];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] rdw(input logic [31:0] a);
    return {rdb(a), rdb(a + 32'd1), rdb(a + 32'd2), rdb(a + 32'd3)};
  endfunction

  assign mem_rdata32 = rdw(mem_addr);
  assign mem_rdata8  = rdb(mem_addr);

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (mem_en && mem_write_op && mem_addr < 32'd60) begin
      if (mem_byte_op) begin
        mem[mem_addr[5:0]] <= mem_wdata[7:0];
      end else begin
        mem[mem_addr[5:0]]         <= mem_wdata[31:24];
        mem[mem_addr[5:0] + 6'd1]  <= mem_wdata[23:16];
        mem[mem_addr[5:0] + 6'd2]  <= mem_wdata[15:8];
        mem[mem_addr[5:0] + 6'd3]  <= mem_wdata[7:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Response monitor: every ack pops the oldest expectation.
  always @(negedge clock) begin
    if (mem_en) en_log.push_back(mem_addr);
    if (a_ack || b_ack) begin
      chk("dual_ack", 32'(a_ack & b_ack), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("ack_port", 32'(b_ack), 32'(got.port_b));
        chk("ack_err", 32'(b_ack ? b_err : a_err), 32'(got.err));
        chk("ack_rdata", b_ack ? b_rdata : a_rdata, got.rdata);
      end
    end
  end

  function automatic vec_t mk(input logic pb, input logic we, input logic [1:0] sz,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input logic er, input logic [31:0] rd, input int lat);
    vec_t v;
    v.port_b = pb; v.we = we; v.size = sz; v.addr = ad; v.wdata = wd;
    v.exp_err = er; v.exp_rdata = rd; v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    bit done;
    int exp_en;
    sb.push_back(exp_t'{v.port_b, v.exp_err, v.exp_rdata});
    en_log.delete();
    if (v.port_b) begin
      b_addr = v.addr; b_we = v.we; b_size = v.size; b_wdata = v.wdata; b_req = 1'b1;
    end else begin
      a_addr = v.addr; a_req = 1'b1;
    end
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 12) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      done = v.port_b ? b_ack : a_ack;
    end
    chk($sformatf("latency[%0d]", idx), 32'(cyc), 32'(v.exp_lat));
    a_req = 1'b0;
    b_req = 1'b0;
    exp_en = v.exp_err ? 0 : ((v.port_b && v.we && v.size == 2'b01) ? 2 : 1);
    chk($sformatf("en_cycles[%0d]", idx), 32'(en_log.size()), 32'(exp_en));
    if (exp_en > 0 && en_log.size() > 0)
      chk($sformatf("en_addr0[%0d]", idx), en_log[0], v.addr);
    if (exp_en > 1 && en_log.size() > 1)
      chk($sformatf("en_addr1[%0d]", idx), en_log[1], v.addr + 32'd1);
    @(negedge clock);
  endtask

  vec_t vecs[18];

  initial begin
    int n, cyc, last;
    bit done;

    vecs[0]  = mk(1, 1, 2'b10, 32'd16, 32'hDEADBEEF, 0, 32'h0, 2);
    vecs[1]  = mk(1, 0, 2'b10, 32'd16, 32'h0, 0, 32'hDEADBEEF, 2);
    vecs[2]  = mk(1, 1, 2'b01, 32'd6, 32'h00001234, 0, 32'h0, 3);
    vecs[3]  = mk(1, 0, 2'b01, 32'd6, 32'h0, 0, 32'h00001234, 2);
    vecs[4]  = mk(1, 0, 2'b00, 32'd7, 32'h0, 0, 32'h00000034, 2);
    vecs[5]  = mk(0, 0, 2'b10, 32'd16, 32'h0, 0, 32'hDEADBEEF, 2);
    vecs[6]  = mk(1, 1, 2'b00, 32'd20, 32'hCAFE0077, 0, 32'h0, 2);
    vecs[7]  = mk(1, 0, 2'b10, 32'd20, 32'h0, 0, 32'h77000000, 2);
    vecs[8]  = mk(0, 0, 2'b10, 32'd2, 32'h0, 1, 32'h0, 1);
    vecs[9]  = mk(1, 1, 2'b01, 32'd5, 32'h0000BBBB, 1, 32'h0, 1);
    vecs[10] = mk(1, 0, 2'b10, 32'd999996, 32'h0, 0, rdw(32'd999996), 2);
    vecs[11] = mk(1, 0, 2'b10, 32'd1000000, 32'h0, 1, 32'h0, 1);
    vecs[12] = mk(1, 0, 2'b00, 32'd1000000, 32'h0, 0, {24'd0, rdb(32'd1000000)}, 2);
    vecs[13] = mk(1, 0, 2'b00, 32'd1000001, 32'h0, 1, 32'h0, 1);
    vecs[14] = mk(1, 0, 2'b10, 32'd999998, 32'h0, 1, 32'h0, 1);
    vecs[15] = mk(1, 0, 2'b10, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1);
    vecs[16] = mk(1, 0, 2'b11, 32'd0, 32'h0, 1, 32'h0, 1);
    vecs[17] = mk(0, 0, 2'b10, 32'd20, 32'h0, 0, 32'h77000000, 2);

    repeat (2) @(negedge clock);
    mem_clr = 1'b0;
    chk("rst_ctrl", 32'({a_ack, a_err, b_ack, b_err, mem_en, mem_write_op, mem_byte_op}), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    chk("mem16", 32'({mem[16], mem[17], mem[18], mem[19]}), 32'hDEADBEEF);
    chk("mem4_7", 32'({mem[4], mem[5], mem[6], mem[7]}), 32'h00001234);

    // Both ports requesting continuously from reset: A first, then strict alternation.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.push_back(exp_t'{1'b0, 1'b0, 32'hDEADBEEF});
    sb.push_back(exp_t'{1'b1, 1'b0, 32'hDEADBEEF});
    sb.push_back(exp_t'{1'b0, 1'b0, 32'hDEADBEEF});
    sb.push_back(exp_t'{1'b1, 1'b0, 32'hDEADBEEF});
    a_addr = 32'd16; b_addr = 32'd16; b_we = 1'b0; b_size = 2'b10;
    a_req = 1'b1; b_req = 1'b1;
    n = 0; cyc = 0; last = -1;
    while (n < 4 && cyc < 40) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (a_ack || b_ack) begin
        n++;
        if (last >= 0) chk("ack_spacing", 32'(cyc - last), 32'd3);
        else chk("first_ack_lat", 32'(cyc), 32'd2);
        last = cyc;
      end
    end
    chk("rr_ack_count", 32'(n), 32'd4);
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clock);

    // Reset lands during the second byte of a halfword store.
    sb.push_back(exp_t'{1'b1, 1'b0, 32'h0});
    b_addr = 32'd8; b_we = 1'b1; b_size = 2'b01; b_wdata = 32'h0000ABCD; b_req = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("acc2_en", 32'(mem_en), 32'd1);
    chk("acc2_addr", mem_addr, 32'd9);
    reset = 1'b1;
    #1;
    chk("midrst_ctrl", 32'({a_ack, b_ack, b_err, mem_en, mem_write_op, mem_byte_op}), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_b_rdata", b_rdata, 32'd0);
    chk("midrst_a_rdata", a_rdata, 32'd0);
    chk("midrst_mem8_9", 32'({mem[8], mem[9]}), 32'h0000AB00);
    @(negedge clock);
    reset = 1'b0;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 12) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      done = b_ack;
    end
    chk("rerun_lat", 32'(cyc), 32'd3);
    b_req = 1'b0;
    chk("rerun_mem8_9", 32'({mem[8], mem[9]}), 32'h0000ABCD);
    @(negedge clock);
    @(negedge clock);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
